envelope_vca: RTL and testbench



---
 rtl/envelope_vca.sv | 232 +++++++++++++++++++++++
 tb/tb_envelope_vca.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/envelope_vca.sv
// Three-voice ADSR envelope generator feeding a sequential shift-add VCA.
// Each request advances one voice's envelope a tick, then scales voice_i by that level.

module vca_mult #(
  parameter int A_W = 24,
  parameter int B_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [A_W-1:0]     a_i,
  input  logic [B_W-1:0]     b_i,
  output logic               ready_o,
  output logic               done_o,
  output logic [A_W+B_W-1:0] prod_o
);
  localparam int P_W = A_W + B_W;
  localparam int C_W = $clog2(B_W + 1);

  logic [P_W-1:0] a_q;
  logic [P_W-1:0] acc_q;
  logic [B_W-1:0] b_q;
  logic [C_W-1:0] cnt_q;
  logic           busy_q;

  assign ready_o = !busy_q;
  assign done_o  = busy_q && (cnt_q == C_W'(B_W));
  assign prod_o  = acc_q;

  // B is unsigned, so summing shifted copies of the sign-extended A is exact mod 2^P_W.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q    <= '0;
      acc_q  <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i && !busy_q) begin
      a_q    <= {{B_W{a_i[A_W-1]}}, a_i};
      b_q    <= b_i;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (done_o) begin
      busy_q <= 1'b0;
    end else if (busy_q) begin
      if (b_q[0]) acc_q <= acc_q + a_q;
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q + C_W'(1);
    end
  end
endmodule

module envelope_vca #(
  parameter int NUM_VOICES = 3,
  parameter int MULT_A_W   = 24,
  parameter int MULT_B_W   = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic [9:0]                   voice_i,
  input  logic [1:0]                   voice_idx_i,
  input  logic                         gate_i,
  input  logic [3:0]                   attack_i,
  input  logic [3:0]                   decay_i,
  input  logic [3:0]                   sustain_i,
  input  logic [3:0]                   release_i,
  output logic                         ready_o,
  output logic [MULT_A_W+MULT_B_W-1:0] prod_o,
  output logic [1:0]                   dbg_state_o
);
  // Handshake: a request transfers on a clock edge where start_i=1, ready_o=1 and
  // voice_idx_i names a stored voice; mult_start/mult_ready follow the same rule internally.
  typedef enum logic [1:0] {C_IDLE, C_ENV, C_MLOAD, C_MULT} ctrl_e;
  typedef enum logic [1:0] {EG_ATTACK, EG_DECAY, EG_RELEASE} eg_e;

  ctrl_e ctrl_q, ctrl_d;
  logic  accept, env_we, prod_we, mult_start, mult_ready, mult_done;
  logic [MULT_A_W+MULT_B_W-1:0] mult_prod;

  logic [1:0] idx_q;
  logic       gate_q;
  logic [3:0] att_q, dec_q, sus_q, rel_q;

  eg_e        est_q [NUM_VOICES];
  logic [7:0] env_q [NUM_VOICES];
  logic [10:0] rc_q [NUM_VOICES];
  logic [4:0] ec_q  [NUM_VOICES];
  logic       gp_q  [NUM_VOICES];

  eg_e        nx_st;
  logic [7:0] nx_env, target;
  logic [10:0] nx_rc;
  logic [4:0] nx_ec;
  logic [3:0] rate_idx;
  logic       step;

  function automatic logic [10:0] rate_lut(input logic [3:0] i);
    logic [10:0] r;
    case (i)
      4'd0:  r = 11'd1;    4'd1:  r = 11'd2;    4'd2:  r = 11'd4;    4'd3:  r = 11'd6;
      4'd4:  r = 11'd9;    4'd5:  r = 11'd14;   4'd6:  r = 11'd17;   4'd7:  r = 11'd20;
      4'd8:  r = 11'd25;   4'd9:  r = 11'd61;   4'd10: r = 11'd122;  4'd11: r = 11'd195;
      4'd12: r = 11'd244;  4'd13: r = 11'd732;  4'd14: r = 11'd1220; default: r = 11'd1953;
    endcase
    return r;
  endfunction

  // Steps per decrement grow as the level falls, approximating an exponential tail.
  function automatic logic [4:0] exp_period(input logic [7:0] e);
    logic [4:0] p;
    if (e >= 8'd94)      p = 5'd1;
    else if (e >= 8'd55) p = 5'd2;
    else if (e >= 8'd27) p = 5'd4;
    else if (e >= 8'd15) p = 5'd8;
    else if (e >= 8'd7)  p = 5'd16;
    else                 p = 5'd30;
    return p;
  endfunction

  assign accept = start_i && (ctrl_q == C_IDLE) && (int'(voice_idx_i) < NUM_VOICES);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ctrl_q <= C_IDLE;
    else         ctrl_q <= ctrl_d;
  end

  always_comb begin
    ctrl_d = ctrl_q;
    case (ctrl_q)
      C_IDLE:  if (accept) ctrl_d = C_ENV;
      C_ENV:   ctrl_d = C_MLOAD;
      C_MLOAD: if (mult_ready) ctrl_d = C_MULT;
      C_MULT:  if (mult_done) ctrl_d = C_IDLE;
      default: ctrl_d = C_IDLE;
    endcase
  end

  always_comb begin
    ready_o    = (ctrl_q == C_IDLE);
    env_we     = (ctrl_q == C_ENV);
    mult_start = (ctrl_q == C_MLOAD) && mult_ready;
    prod_we    = (ctrl_q == C_MULT) && mult_done;
  end

  assign dbg_state_o = ctrl_q;

  // One envelope tick for the latched voice: gate edges first, then rate and level.
  always_comb begin
    nx_st  = est_q[idx_q];
    nx_env = env_q[idx_q];
    nx_rc  = rc_q[idx_q];
    nx_ec  = ec_q[idx_q];
    target = {sus_q, sus_q};
    if (gate_q && !gp_q[idx_q]) begin
      nx_st = EG_ATTACK;
      nx_rc = '0;
    end else if (!gate_q && gp_q[idx_q]) begin
      nx_st = EG_RELEASE;
      nx_rc = '0;
    end
    case (nx_st)
      EG_ATTACK: rate_idx = att_q;
      EG_DECAY:  rate_idx = dec_q;
      default:   rate_idx = rel_q;
    endcase
    nx_rc = nx_rc + 11'd1;
    step  = (nx_rc >= rate_lut(rate_idx));
    if (step) nx_rc = '0;
    if (step && nx_st == EG_ATTACK) begin
      if (nx_env != 8'hFF) nx_env = nx_env + 8'd1;
      if (nx_env == 8'hFF) nx_st = EG_DECAY;
    end else if (step && ((nx_st == EG_DECAY && nx_env > target) ||
                          (nx_st == EG_RELEASE && nx_env != 8'd0))) begin
      if (nx_ec + 5'd1 >= exp_period(nx_env)) begin
        nx_ec  = '0;
        nx_env = nx_env - 8'd1;
      end else begin
        nx_ec = nx_ec + 5'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q  <= '0;
      gate_q <= 1'b0;
      att_q  <= '0;
      dec_q  <= '0;
      sus_q  <= '0;
      rel_q  <= '0;
      prod_o <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        est_q[v] <= EG_RELEASE;
        env_q[v] <= '0;
        rc_q[v]  <= '0;
        ec_q[v]  <= '0;
        gp_q[v]  <= 1'b0;
      end
    end else begin
      if (accept) begin
        idx_q  <= voice_idx_i;
        gate_q <= gate_i;
        att_q  <= attack_i;
        dec_q  <= decay_i;
        sus_q  <= sustain_i;
        rel_q  <= release_i;
      end
      if (env_we) begin
        est_q[idx_q] <= nx_st;
        env_q[idx_q] <= nx_env;
        rc_q[idx_q]  <= nx_rc;
        ec_q[idx_q]  <= nx_ec;
        gp_q[idx_q]  <= gate_q;
      end
      if (prod_we) prod_o <= mult_prod;
    end
  end

  vca_mult #(.A_W(MULT_A_W), .B_W(MULT_B_W)) u_mult (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (mult_start),
    .a_i     ({{(MULT_A_W-10){voice_i[9]}}, voice_i}),
    .b_i     ({{(MULT_B_W-8){1'b0}}, env_q[idx_q]}),
    .ready_o (mult_ready),
    .done_o  (mult_done),
    .prod_o  (mult_prod)
  );
endmodule

// File: tb/tb_envelope_vca.sv
// Bench for envelope_vca: directed phases plus randomized voice traffic,
// each product compared against a behavioural ADSR model.

module tb_envelope_vca;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [9:0]  voice_i;
  logic [1:0]  voice_idx_i;
  logic        gate_i;
  logic [3:0]  attack_i, decay_i, sustain_i, release_i;
  logic        ready_o;
  logic [39:0] prod_o;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  logic [39:0] exp_q[$];
  logic [39:0] last_prod = '0;

  localparam int ST_A = 0, ST_D = 1, ST_R = 2;
  int RATE[16] = '{1, 2, 4, 6, 9, 14, 17, 20, 25, 61, 122, 195, 244, 732, 1220, 1953};
  int m_env[3], m_st[3], m_rc[3], m_ec[3];
  bit m_gp[3];

  envelope_vca dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .voice_i     (voice_i),
    .voice_idx_i (voice_idx_i),
    .gate_i      (gate_i),
    .attack_i    (attack_i),
    .decay_i     (decay_i),
    .sustain_i   (sustain_i),
    .release_i   (release_i),
    .ready_o     (ready_o),
    .prod_o      (prod_o),
    .dbg_state_o (dbg_state)
  );

  // clock / watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #3000000;
    $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // behavioural model
  function automatic void m_reset();
    for (int v = 0; v < 3; v++) begin
      m_env[v] = 0; m_st[v] = ST_R; m_rc[v] = 0; m_ec[v] = 0; m_gp[v] = 1'b0;
    end
  endfunction

  function automatic int exp_period(int e);
    if (e >= 94) return 1;
    if (e >= 55) return 2;
    if (e >= 27) return 4;
    if (e >= 15) return 8;
    if (e >= 7)  return 16;
    return 30;
  endfunction

  function automatic void m_tick(int v, bit g, int a, int d, int s, int r);
    int rate;
    if (g && !m_gp[v]) begin m_st[v] = ST_A; m_rc[v] = 0; end
    else if (!g && m_gp[v]) begin m_st[v] = ST_R; m_rc[v] = 0; end
    m_gp[v] = g;
    rate = (m_st[v] == ST_A) ? RATE[a] : (m_st[v] == ST_D) ? RATE[d] : RATE[r];
    m_rc[v]++;
    if (m_rc[v] < rate) return;
    m_rc[v] = 0;
    if (m_st[v] == ST_A) begin
      if (m_env[v] < 255) m_env[v]++;
      if (m_env[v] == 255) m_st[v] = ST_D;
    end else if ((m_st[v] == ST_D && m_env[v] > s * 17) || (m_st[v] == ST_R && m_env[v] > 0)) begin
      m_ec[v]++;
      if (m_ec[v] >= exp_period(m_env[v])) begin
        m_ec[v] = 0;
        m_env[v]--;
      end
    end
  endfunction

  // driver: one full request, checking drop of ready, latency and product
  task automatic do_req(input int idx, input bit g, input int a, input int d, input int s,
                        input int r, input int v, input bit poke);
    int cyc;
    logic [39:0] e40;
    @(negedge clk_i);
    voice_idx_i = 2'(idx); gate_i = g; voice_i = 10'(v);
    attack_i = 4'(a); decay_i = 4'(d); sustain_i = 4'(s); release_i = 4'(r);
    start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    m_tick(idx, g, a, d, s, r);
    exp_q.push_back(40'(longint'(v) * longint'(m_env[idx])));
    cyc = 0;
    do begin
      @(posedge clk_i); #1;
      cyc++;
      if (cyc == 1) chk("ready_drop", ready_o, 0);
      if (poke && cyc == 4) begin start_i = 1'b1; voice_idx_i = 2'((idx + 1) % 3); gate_i = !g; end
      if (poke && cyc == 5) start_i = 1'b0;
    end while (!ready_o && cyc < 40);
    chk("latency", cyc, 19);
    e40 = exp_q.pop_front();
    chk("prod", $signed(prod_o), $signed(e40));
    last_prod = e40;
  endtask

  task automatic ignore_idx3();
    @(negedge clk_i);
    voice_idx_i = 2'd3; gate_i = 1'b1; start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    chk("idx3_ready", ready_o, 1);
    repeat (3) @(posedge clk_i);
    #1;
    chk("idx3_ready_late", ready_o, 1);
    chk("idx3_prod", $signed(prod_o), $signed(last_prod));
  endtask

  initial begin
    int n;
    start_i = 1'b0; voice_i = '0; voice_idx_i = '0; gate_i = 1'b0;
    attack_i = '0; decay_i = '0; sustain_i = '0; release_i = '0;
    rst_ni = 1'b0;
    m_reset();
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_ready", ready_o, 1);
    chk("reset_prod", $signed(prod_o), 0);
    @(negedge clk_i) rst_ni = 1'b1;
    #1;
    chk("post_reset_ready", ready_o, 1);

    // gate low from reset: level stays at zero
    do_req(0, 0, 0, 0, 0, 0, 100, 0);
    chk("gate0_prod", $signed(prod_o), 0);

    // fastest attack to full scale
    for (int i = 0; i < 255; i++) do_req(0, 1, 0, 15, 15, 0, 511, 0);
    chk("attack_top_prod", $signed(prod_o), 130305);

    do_req(0, 1, 0, 15, 15, 0, -512, 0);
    chk("neg_prod", $signed(prod_o), -130560);
    chk("neg_sign_ext", prod_o[39:32], 8'hFF);

    // decay to sustain 0x88 and hold
    n = 0;
    while (m_env[0] != 136 && n < 400) begin
      do_req(0, 1, 0, 0, 8, 0, int'($urandom_range(0, 1023)) - 512, 0);
      n++;
    end
    for (int i = 0; i < 8; i++) do_req(0, 1, 0, 0, 8, 0, 1, 0);
    chk("sustain_hold", $signed(prod_o), 136);

    // release to zero and hold
    n = 0;
    while (m_env[0] != 0 && n < 2000) begin
      do_req(0, 0, 0, 0, 8, 0, int'($urandom_range(0, 1023)) - 512, 0);
      n++;
    end
    for (int i = 0; i < 5; i++) do_req(0, 0, 0, 0, 8, 0, 1, 0);
    chk("release_floor", $signed(prod_o), 0);

    // interleaved voices with busy pokes and ignored index 3
    for (int i = 0; i < 150; i++) begin
      do_req(int'($urandom_range(0, 2)), $urandom_range(0, 2) != 0,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 1023)) - 512, $urandom_range(0, 5) == 0);
      if (i % 15 == 7) ignore_idx3();
    end

    // attack index 1 on voice 1: one step every second update
    n = 0;
    while (m_env[1] != 0 && n < 2000) begin
      do_req(1, 0, 0, 0, 0, 0, 3, 0);
      n++;
    end
    do_req(1, 0, 0, 0, 0, 0, 1, 0);
    do_req(1, 1, 1, 15, 15, 0, 1, 0);
    chk("att1_u1", $signed(prod_o), 0);
    do_req(1, 1, 1, 15, 15, 0, 1, 0);
    chk("att1_u2", $signed(prod_o), 1);
    do_req(1, 1, 1, 15, 15, 0, 1, 0);
    chk("att1_u3", $signed(prod_o), 1);
    do_req(1, 1, 1, 15, 15, 0, 1, 0);
    chk("att1_u4", $signed(prod_o), 2);

    // retrigger voice 0 mid-release at 0x40
    do_req(0, 0, 0, 15, 15, 0, 5, 0);
    n = 0;
    while (m_env[0] != 255 && n < 400) begin
      do_req(0, 1, 0, 15, 15, 0, int'($urandom_range(0, 1023)) - 512, 0);
      n++;
    end
    n = 0;
    while (m_env[0] != 64 && n < 2000) begin
      do_req(0, 0, 0, 15, 15, 0, int'($urandom_range(0, 1023)) - 512, 0);
      n++;
    end
    do_req(0, 1, 0, 15, 15, 0, 1, 0);
    chk("retrigger", $signed(prod_o), 65);

    // reset in the middle of an operation
    @(negedge clk_i);
    voice_idx_i = 2'd2; gate_i = 1'b1; attack_i = 4'd0; voice_i = 10'd200; start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    repeat (6) @(posedge clk_i);
    #1 rst_ni = 1'b0;
    #1;
    chk("midrst_ready", ready_o, 1);
    chk("midrst_prod", $signed(prod_o), 0);
    chk("midrst_state", dbg_state, 0);
    @(negedge clk_i) rst_ni = 1'b1;
    m_reset();
    do_req(2, 1, 0, 15, 15, 0, 77, 0);
    chk("post_rst_first", $signed(prod_o), 77);
    do_req(0, 0, 0, 0, 0, 0, 300, 0);
    chk("post_rst_v0", $signed(prod_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
